// File: rtl/caches_types_pkg.sv
// caches_types_pkg -- types shared by the cache side of the memory system.
//   arb_state_t : memory arbiter FSM states.
//   arb_pick()  : arbitration decision used on every re-arbitration point.
package caches_types_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        IGRANT = 2'b01,
        DGRANT = 2'b10
    } arb_state_t;

    // Dcache has priority unless the starvation guard forces the icache in.
    function automatic arb_state_t arb_pick(input logic dreq,
                                            input logic ireq,
                                            input logic starve);
        arb_state_t pick;
        if (starve && ireq) begin
            pick = IGRANT;
        end else if (dreq) begin
            pick = DGRANT;
        end else if (ireq) begin
            pick = IGRANT;
        end else begin
            pick = IDLE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared CPU-level types.
//   word_t     : 32-bit machine word.
//   ramstate_t : memory port status reported by the RAM model/controller.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

endpackage

// File: rtl/flex_counter.sv
// flex_counter -- generic up-counter with synchronous clear.
//   CLK, RST (async, active-high), clear (sync, wins over count_en),
//   count_en (increment by one), count (current value, wraps naturally).
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             count_en,
    output logic [WIDTH-1:0] count
);

    // Count register: clear has priority over increment.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + WIDTH'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- arbitrates a single RAM port between icache and dcache.
//   Optional feature: define ARB_STARVE_GUARD_EN to enable the icache
//   starvation guard (forces an icache grant after STARVE_LIMIT consecutive
//   dcache blocks while the icache is waiting). Default: strict dcache priority.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   iREN, iaddr         icache read request / word address
//   iwait, iload        icache stall (low only on completion) / read data
//   dREN, dWEN          dcache read / write request (mutually exclusive)
//   daddr, dstore       dcache word address / write data
//   dwait, dload        dcache stall (low only on completion) / read data
//   ramREN, ramWEN      memory port read / write strobes
//   ramaddr, ramstore   memory port address / write data
//   ramload, ramstate   memory read data / memory status (ramstate_t)
//   arb_err             sticky: ramstate==ERROR seen while a grant was active
module mem_arbiter
    import cpu_types_pkg::*;
    import caches_types_pkg::*;
#(
    parameter int BLOCK_WORDS  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        arb_err
);

    localparam int WCNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(BLOCK_WORDS - 1);

    arb_state_t        state_r;
    arb_state_t        state_next_s;
    logic [WCNT_W-1:0] wcnt_r;
    logic [WCNT_W-1:0] wcnt_next_s;
    logic              dreq_s;
    logic              icomplete_s;
    logic              dcomplete_s;
    logic              block_done_s;
    logic              starve_force_s;

    assign dreq_s       = dREN | dWEN;
    assign icomplete_s  = (state_r == IGRANT) && iREN   && (ramstate == ACCESS);
    assign dcomplete_s  = (state_r == DGRANT) && dreq_s && (ramstate == ACCESS);
    assign block_done_s = dcomplete_s && (wcnt_r == WCNT_LAST);

`ifdef ARB_STARVE_GUARD_EN
    localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);

    logic [SCNT_W-1:0] starve_cnt_s;
    logic              starve_inc_s;
    logic              starve_clear_s;

    assign starve_inc_s   = block_done_s & iREN;
    assign starve_clear_s = ~iREN | ((state_r != IGRANT) && (state_next_s == IGRANT));

    // Count includes the block finishing this cycle so the decision taken on
    // the STARVE_LIMIT-th block completion already hands over to the icache.
    assign starve_force_s = iREN &&
        ((int'(starve_cnt_s) + (starve_inc_s ? 1 : 0)) >= STARVE_LIMIT);

    flex_counter #(
        .WIDTH (SCNT_W)
    ) u_starve_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (starve_clear_s),
        .count_en (starve_inc_s),
        .count    (starve_cnt_s)
    );
`else
    // Strict dcache priority; the limit has no effect in this build.
    assign starve_force_s = (STARVE_LIMIT < 0) ? iREN : 1'b0;
`endif

    // Next-state and word-counter logic; re-arbitrates on completion/release.
    always_comb begin
        state_next_s = state_r;
        wcnt_next_s  = wcnt_r;
        case (state_r)
            IDLE: begin
                state_next_s = arb_pick(dreq_s, iREN, starve_force_s);
                wcnt_next_s  = '0;
            end
            IGRANT: begin
                wcnt_next_s = '0;
                if (icomplete_s) begin
                    state_next_s = arb_pick(dreq_s, iREN, starve_force_s);
                end else if (!iREN) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = IGRANT;
                end
            end
            DGRANT: begin
                if (!dreq_s) begin
                    // dcache abandoned the block: release the lock now.
                    wcnt_next_s  = '0;
                    state_next_s = arb_pick(dreq_s, iREN, starve_force_s);
                end else if (dcomplete_s) begin
                    if (wcnt_r == WCNT_LAST) begin
                        wcnt_next_s  = '0;
                        state_next_s = arb_pick(dreq_s, iREN, starve_force_s);
                    end else begin
                        wcnt_next_s  = wcnt_r + WCNT_W'(1);
                        state_next_s = DGRANT;
                    end
                end else begin
                    // BUSY / ERROR / FREE: hold grant and counter.
                    wcnt_next_s  = wcnt_r;
                    state_next_s = DGRANT;
                end
            end
            default: begin
                state_next_s = IDLE;
                wcnt_next_s  = '0;
            end
        endcase
    end

    // FSM state and word counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
            wcnt_r  <= '0;
        end else begin
            state_r <= state_next_s;
            wcnt_r  <= wcnt_next_s;
        end
    end

    // Sticky error flag: any ERROR status while a requester holds the grant.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            arb_err <= 1'b0;
        end else if ((state_r != IDLE) && (ramstate == ERROR)) begin
            arb_err <= 1'b1;
        end else begin
            arb_err <= arb_err;
        end
    end

    assign iload = ramload;
    assign dload = ramload;

    // RAM port mux and stall generation; state is async-reset so outputs
    // fall to their idle values the moment RST rises.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'h0000_0000;
        ramstore = 32'h0000_0000;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state_r)
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = ~icomplete_s;
            end
            DGRANT: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = ~dcomplete_s;
            end
            default: begin
                ramREN = 1'b0;
                ramWEN = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- scoreboard bench for mem_arbiter. Stimulus pushes the
// expected completions; a monitor pops them whenever iwait or dwait drops.
// The RAM model returns ramaddr ^ 32'hA5A5_0000 as read data.
module tb_mem_arbiter;
    import cpu_types_pkg::*;
    import caches_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait, ramREN, ramWEN, arb_err;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    typedef struct {
        logic        is_d;
        logic        is_w;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 CLK = ~CLK;

    assign ramload = ramaddr ^ 32'hA5A5_0000;

    mem_arbiter dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic is_d, input logic is_w,
                        input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.is_w = is_w;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every completion cycle is matched against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST !== 1'b1 && (iwait === 1'b0 || dwait === 1'b0)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_complete", 32'({iwait, dwait}), 32'h3);
                end else begin
                    e = exp_q.pop_front();
                    check("complete_side", 32'({iwait, dwait}),
                          e.is_d ? 32'h2 : 32'h1);
                    check("complete_addr", ramaddr, e.addr);
                    if (e.is_d && e.is_w) begin
                        check("write_wen", 32'(ramWEN), 32'h1);
                        check("write_data", ramstore, e.data);
                    end else if (e.is_d) begin
                        check("dload", dload, e.data);
                    end else begin
                        check("iload", iload, e.data);
                    end
                end
            end
        end
    end

    initial begin
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramstate = FREE;
        #1;
        check("rst_iwait", 32'(iwait), 32'h1);
        check("rst_dwait", 32'(dwait), 32'h1);
        check("rst_ram_strobes", 32'({ramREN, ramWEN}), 32'h0);
        check("rst_ramaddr", ramaddr, 32'h0);
        check("rst_ramstore", ramstore, 32'h0);
        check("rst_arb_err", 32'(arb_err), 32'h0);
        tick(); tick();
        RST = 1'b0;
        tick();

        // Lone icache read, two BUSY cycles then ACCESS.
        iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY;
        push(1'b0, 1'b0, 32'h40, 32'hA5A5_0040);
        #1 check("i_idle_ramren", 32'(ramREN), 32'h0);
        check("i_idle_iwait", 32'(iwait), 32'h1);
        tick();
        check("i_c1_ramaddr", ramaddr, 32'h40);
        check("i_c1_ramren", 32'(ramREN), 32'h1);
        check("i_c1_iwait", 32'(iwait), 32'h1);
        tick();
        check("i_c2_iwait", 32'(iwait), 32'h1);
        tick();
        ramstate = ACCESS;
        #1 check("i_access_iwait", 32'(iwait), 32'h0);
        tick();
        iREN = 1'b0; ramstate = FREE;
        #1 check("i_drop_iwait", 32'(iwait), 32'h1);
        tick();
        check("i_idle_after", 32'(ramREN), 32'h0);

        // Dcache block of two words while the icache also waits.
        dREN = 1'b1; daddr = 32'h100; iREN = 1'b1; iaddr = 32'h80; ramstate = ACCESS;
        push(1'b1, 1'b0, 32'h100, 32'hA5A5_0100);
        push(1'b1, 1'b0, 32'h104, 32'hA5A5_0104);
        push(1'b0, 1'b0, 32'h80, 32'hA5A5_0080);
        #1 check("d_idle_iwait", 32'(iwait), 32'h1);
        tick();
        check("d_w0_iwait", 32'(iwait), 32'h1);
        check("d_w0_dwait", 32'(dwait), 32'h0);
        tick();
        daddr = 32'h104;
        #1 check("d_w1_iwait", 32'(iwait), 32'h1);
        check("d_w1_dwait", 32'(dwait), 32'h0);
        tick();
        dREN = 1'b0;
        #1 check("d_release_ramren", 32'(ramREN), 32'h0);
        check("d_release_iwait", 32'(iwait), 32'h1);
        tick();
        check("i_after_block_ramaddr", ramaddr, 32'h80);
        check("i_after_block_iwait", 32'(iwait), 32'h0);
        tick();
        iREN = 1'b0; ramstate = FREE;
        tick();

        // Single dcache write then dWEN dropped: lock releases.
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF; ramstate = ACCESS;
        push(1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF);
        tick();
        check("w_wen", 32'(ramWEN), 32'h1);
        tick();
        dWEN = 1'b0;
        #1 check("w_drop_wen", 32'(ramWEN), 32'h0);
        check("w_drop_dwait", 32'(dwait), 32'h1);
        tick();
        check("w_idle_strobes", 32'({ramREN, ramWEN}), 32'h0);
        ramstate = FREE;
        tick();

        // ERROR for one cycle mid-grant.
        dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
        push(1'b1, 1'b0, 32'h300, 32'hA5A5_0300);
        tick();
        check("e_busy_dwait", 32'(dwait), 32'h1);
        check("e_busy_err", 32'(arb_err), 32'h0);
        tick();
        ramstate = ERROR;
        #1 check("e_error_dwait", 32'(dwait), 32'h1);
        tick();
        ramstate = ACCESS;
        #1 check("e_err_set", 32'(arb_err), 32'h1);
        check("e_access_dwait", 32'(dwait), 32'h0);
        tick();
        dREN = 1'b0; ramstate = FREE;
        tick();
        check("e_err_sticky", 32'(arb_err), 32'h1);

        // Reset mid-block after word 0; new block restarts cleanly.
        dREN = 1'b1; daddr = 32'h400; ramstate = ACCESS;
        push(1'b1, 1'b0, 32'h400, 32'hA5A5_0400);
        tick();
        tick();
        daddr = 32'h404; ramstate = BUSY; RST = 1'b1;
        #1 check("r_strobes", 32'({ramREN, ramWEN}), 32'h0);
        check("r_dwait", 32'(dwait), 32'h1);
        check("r_ramaddr", ramaddr, 32'h0);
        check("r_arb_err", 32'(arb_err), 32'h0);
        tick();
        RST = 1'b0; daddr = 32'h500; ramstate = ACCESS;
        push(1'b1, 1'b0, 32'h500, 32'hA5A5_0500);
        push(1'b1, 1'b0, 32'h504, 32'hA5A5_0504);
        #1 check("r_idle_ramren", 32'(ramREN), 32'h0);
        tick();
        tick();
        daddr = 32'h504;
        tick();
        dREN = 1'b0; ramstate = FREE;
        tick();
        tick();

        // Continuous dcache with icache held: starvation behaviour.
        dREN = 1'b1; daddr = 32'h600; iREN = 1'b1; iaddr = 32'h700; ramstate = ACCESS;
`ifdef ARB_STARVE_GUARD_EN
        for (int k = 0; k < 8; k++) push(1'b1, 1'b0, 32'h600, 32'hA5A5_0600);
        push(1'b0, 1'b0, 32'h700, 32'hA5A5_0700);
        for (int k = 0; k < 4; k++) push(1'b1, 1'b0, 32'h600, 32'hA5A5_0600);
`else
        for (int k = 0; k < 13; k++) push(1'b1, 1'b0, 32'h600, 32'hA5A5_0600);
`endif
        for (int c = 0; c < 14; c++) tick();
        dREN = 1'b0; iREN = 1'b0; ramstate = FREE;
        tick();
        tick();
        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
